fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the FIFO buffer: pops bytes from the FIFO read side and serializes each as one 8N1-style UART frame on `tx`.
- Drives the FIFO's `rd` input and reads its `r_data`/`empty` outputs directly. FIFO `r_data` is the combinational head-of-queue value.
- Contains its own programmable baud-tick generator with 16x oversampling. Ticks are counted per bit.

Parameters:
- DATA_WIDTH, 8, bits per frame; must match the FIFO's DATA_WIDTH.
- SB_TICK, 16, stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR_WIDTH, 11, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dvsr  in  DVSR_WIDTH  baud divisor; tick period = dvsr+1 clocks.
- tx_en  in  1  permits starting a new frame.
- empty  in  1  FIFO empty flag.
- r_data  in  DATA_WIDTH  FIFO head data (valid whenever empty=0).
- rd  out  1  FIFO pop strobe, one clock wide.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  high while state != IDLE.
- tx_done_tick  out  1  one-clock pulse at end of each frame's stop bit.

Behaviour:
- Reset (sync, at clk edge with reset=1) sets:
  - state=IDLE, tx=1, tick counter=0, bit/tick counters=0, shift register=0.
  - rd=0, tx_busy=0, tx_done_tick=0.
  - Reset overrides everything, including mid-frame: the line returns high next cycle, the frame is abandoned, and no pop occurs.
- Baud generator:
  - Counter 0..dvsr; s_tick=1 on the cycle the counter equals dvsr, then it wraps to 0.
  - dvsr=0 gives a tick every clock.
  - The counter is held at 0 while IDLE and runs from the cycle after frame start, so frame timing is deterministic.
  - dvsr changes only while idle. A mid-frame change takes effect at the next counter comparison (no glitch protection).
- rd is combinational: rd = (state==IDLE) & tx_en & ~empty & ~reset.
  - rd is never asserted when empty=1.
- Frame start: on the edge where rd=1, the shift register loads r_data, state goes to START and tx becomes 0 starting the next cycle. Latency from pop to start bit is one clock.
- FSM:
  - IDLE: tx=1. On the pop condition -> START.
  - START: tx=0 for 16 ticks -> DATA, bit counter=0.
  - DATA: tx=shift[0]. Every 16 ticks, shift right and increment the bit counter. After bit DATA_WIDTH-1 completes -> STOP.
  - STOP: tx=1 for SB_TICK ticks. On the final tick, tx_done_tick=1 for that cycle, then -> IDLE.
- Ordering: bits are sent LSB first.
- Frame length in clocks: (16*(1+DATA_WIDTH)+SB_TICK)*(dvsr+1).
- Back-to-back frames: at least one IDLE clock (tx=1) between a stop bit and the next start bit. If data is waiting, the next pop occurs on that IDLE clock.
- tx_en=0 mid-frame: the current frame completes and no new pop follows.
- FIFO becoming empty, or being written, mid-frame has no effect on the frame in progress.
- Tick counter width is 4 bits for the 16-tick phases. The stop-phase counter is sized by $clog2(SB_TICK). The bit counter is sized by $clog2(DATA_WIDTH).

Decomposition:
- Package uart_pkg:
  - typedef enum state_t {IDLE, START, DATA, STOP}.
  - localparam OVERSAMPLE=16.
- Sub-module baud_gen: parameter DVSR_WIDTH; ports clk, reset, clr, dvsr, s_tick. It is instantiated once in fifo_uart_tx, with clr=(state==IDLE).
- Top level for system integration: fifo + fifo_uart_tx, with rd, empty and r_data connected by name.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset 3 clocks with empty=0, tx_en=1.
  - Required: tx=1, rd=0, tx_busy=0 throughout reset; first rd pulse exactly one clock after reset deasserts.
- Single byte:
  - Stimulus: dvsr=0, SB_TICK=16, FIFO holds 0xA5.
  - Required: rd high 1 clock; tx low 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high 16 clocks.
  - Required: tx_done_tick on clock 160 after the start bit begins; empty asserts after the pop.
- Back-to-back:
  - Stimulus: FIFO holds 0x00 then 0xFF, dvsr=2.
  - Required: each frame is 480 clocks; exactly one idle-high clock between frames; two rd pulses total; received bytes 0x00 then 0xFF.
- Empty and enable gating:
  - Stimulus: empty=1 with tx_en=1; then empty=0 with tx_en=0.
  - Required: no rd, tx stays 1 in both cases. Raising tx_en=1 produces rd in the same cycle.
  - Stimulus: deassert tx_en mid-frame.
  - Required: the frame completes with no further pop.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 of 0x3C.
  - Required: tx=1 and tx_busy=0 the next clock. After release, the next FIFO entry (not 0x3C) is popped and sent.
- Stop length:
  - Stimulus: SB_TICK=32, dvsr=0.
  - Required: stop bit lasts 32 clocks; frame lasts 176 clocks; tx_done_tick on the last stop clock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/baud_gen.sv
// Programmable baud tick generator: one s_tick every dvsr+1 clocks, held cleared by clr.
module baud_gen #(
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  s_tick
);

  logic [DVSR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == dvsr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Suppressed while cleared so the first tick lands dvsr+1 clocks into the frame.
  assign s_tick = ~clr & (cnt == dvsr);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and sends each as an LSB-first 8N1-style UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  tx_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [3:0]    S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DATA_WIDTH - 1);

  state_t                state;
  logic [3:0]            s_reg;
  logic [SW-1:0]         sb_reg;
  logic [NW-1:0]         n_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  tx_reg;
  logic                  s_tick;

  baud_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .dvsr  (dvsr),
    .s_tick(s_tick)
  );

  assign rd = (state == IDLE) & tx_en & ~empty & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_reg  <= '0;
      sb_reg <= '0;
      n_reg  <= '0;
      b_reg  <= '0;
      tx_reg <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd) begin
            state  <= START;
            b_reg  <= r_data;
            s_reg  <= '0;
            tx_reg <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == S_LAST) begin
              state  <= DATA;
              s_reg  <= '0;
              n_reg  <= '0;
              tx_reg <= b_reg[0];
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == S_LAST) begin
              s_reg <= '0;
              b_reg <= b_reg >> 1;
              // tx is registered, so it is loaded with the next bit one shift ahead.
              if (n_reg == N_LAST) begin
                state  <= STOP;
                sb_reg <= '0;
                tx_reg <= 1'b1;
              end else begin
                n_reg  <= n_reg + 1'b1;
                tx_reg <= b_reg[1];
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (sb_reg == SB_LAST) begin
              state <= IDLE;
            end else begin
              sb_reg <= sb_reg + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = (state == STOP) & s_tick & (sb_reg == SB_LAST) & ~reset;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a behavioural FIFO feeds the transmitter, a line monitor decodes frames.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        tx_en;
  logic        empty;
  logic [7:0]  r_data;
  logic        rd, tx, tx_busy, done;

  // Second instance with a two-stop-bit frame.
  logic        empty2, tx_en2;
  logic [7:0]  r_data2;
  logic        rd2, tx2, busy2, done2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_count = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         frame_ends[$];
  bit         mon_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .DVSR_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .tx_en(tx_en), .empty(empty),
    .r_data(r_data), .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(done)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(32), .DVSR_WIDTH(11)) dut32 (
    .clk(clk), .reset(reset), .dvsr(11'd0), .tx_en(tx_en2), .empty(empty2),
    .r_data(r_data2), .rd(rd2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
  );

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void refresh();
    empty  = (fifo_q.size() == 0);
    r_data = empty ? 8'h00 : fifo_q[0];
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    fifo_q.push_back(b);
    if (expect_tx) exp_q.push_back(b);
    refresh();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  // FIFO read side: pop on any edge where rd was high.
  always @(posedge clk) begin
    bit do_pop;
    do_pop = (rd === 1'b1);
    if (do_pop) rd_count++;
    #1;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Line monitor: decodes each frame at mid-bit and checks done timing.
  initial begin
    logic       prev_tx = 1'b1;
    logic [7:0] rx;
    int         bp, len;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && prev_tx === 1'b1 && tx === 1'b0) begin
        bp  = 16 * (int'(dvsr) + 1);
        len = (16 * 9 + 16) * (int'(dvsr) + 1);
        mon_busy = 1'b1;
        aborted  = 1'b0;
        rx       = '0;
        frame_starts.push_back(cyc);
        for (int k = 1; k <= len; k++) begin
          if (k > 1) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k == bp / 2) check("start_bit", int'(tx), 0);
          for (int i = 0; i < 8; i++)
            if (k == bp * (i + 1) + bp / 2) rx[i] = tx;
          if (k == bp * 9 + bp / 2) check("stop_bit", int'(tx), 1);
          if (k == len - 1) check("done_early", int'(done), 0);
          if (k == len) check("done_last", int'(done), 1);
        end
        if (!aborted) begin
          frame_ends.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_frame", int'(rx), -1);
          else check("rx_byte", int'(rx), int'(exp_q.pop_front()));
        end
        mon_busy = 1'b0;
      end
      prev_tx = tx;
    end
  end

  initial begin
    int         hits, lows, base, done_k, highs;
    logic       samp[0:200];
    logic       busy177;
    logic [7:0] rx2;

    reset = 1'b1; dvsr = '0; tx_en = 1'b1;
    empty2 = 1'b1; tx_en2 = 1'b0; r_data2 = 8'h5A;
    refresh();
    push_byte(8'hA5, 1'b1);

    // Reset and first pop, then the single 0xA5 frame at dvsr=0.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_rd", int'(rd), 0);
      check("rst_busy", int'(tx_busy), 0);
    end
    reset = 1'b0;
    #1 check("first_rd", int'(rd), 1);
    @(negedge clk);
    check("rd_one_clock", int'(rd), 0);
    check("start_tx_low", int'(tx), 0);
    check("busy_in_frame", int'(tx_busy), 1);
    wait_idle(400);

    // Empty and enable gating.
    hits = 0; lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hits += int'(rd); lows += int'(!tx);
    end
    check("gate_empty_rd", hits, 0);
    check("gate_empty_tx", lows, 0);
    @(posedge clk); #1 tx_en = 1'b0; push_byte(8'h5A, 1'b1);
    hits = 0; lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hits += int'(rd); lows += int'(!tx);
    end
    check("gate_en_rd", hits, 0);
    check("gate_en_tx", lows, 0);
    @(posedge clk); #1 tx_en = 1'b1;
    @(negedge clk);
    check("en_rise_rd", int'(rd), 1);
    base = rd_count;
    @(posedge clk); #1 push_byte(8'h11, 1'b0); tx_en = 1'b0;
    wait_idle(400);
    repeat (20) @(negedge clk);
    check("no_pop_after_en_low", rd_count - base, 1);
    check("idle_tx_high", int'(tx), 1);
    fifo_q.delete(); refresh();

    // Back-to-back frames at dvsr=2.
    @(posedge clk); #1 dvsr = 11'd2; tx_en = 1'b1;
    frame_starts.delete(); frame_ends.delete();
    base = rd_count;
    push_byte(8'h00, 1'b1); push_byte(8'hFF, 1'b1);
    wait_idle(1500);
    check("b2b_pops", rd_count - base, 2);
    check("b2b_frames", frame_ends.size(), 2);
    if (frame_ends.size() == 2 && frame_starts.size() == 2) begin
      check("b2b_len0", frame_ends[0] - frame_starts[0] + 1, 480);
      check("b2b_len1", frame_ends[1] - frame_starts[1] + 1, 480);
      check("b2b_gap", frame_starts[1] - frame_ends[0], 2);
    end

    // Reset during data bit 3 of 0x3C; 0x96 must follow.
    @(posedge clk); #1 dvsr = '0;
    base = rd_count;
    push_byte(8'h3C, 1'b0); push_byte(8'h96, 1'b1);
    for (int i = 0; i < 50 && !mon_busy; i++) @(negedge clk);
    check("rst_mid_started", int'(mon_busy), 1);
    repeat (68) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_busy", int'(tx_busy), 0);
    check("rst_mid_rd", int'(rd), 0);
    @(posedge clk); #1 reset = 1'b0;
    wait_idle(400);
    check("rst_mid_pops", rd_count - base, 2);

    // Two stop bits on the SB_TICK=32 instance.
    @(posedge clk); #1 empty2 = 1'b0; tx_en2 = 1'b1;
    @(negedge clk);
    check("sb32_rd", int'(rd2), 1);
    @(posedge clk); #1 empty2 = 1'b1;
    done_k = 0; busy177 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      samp[k] = tx2;
      if (done2 && done_k == 0) done_k = k;
      if (k == 177) busy177 = busy2;
    end
    for (int i = 0; i < 8; i++) rx2[i] = samp[24 + 16 * i];
    highs = 0;
    for (int k = 145; k <= 176; k++) highs += int'(samp[k]);
    check("sb32_start", int'(samp[8]), 0);
    check("sb32_byte", int'(rx2), 8'h5A);
    check("sb32_last_data", int'(samp[144]), 0);
    check("sb32_stop_len", highs, 32);
    check("sb32_done_clock", done_k, 176);
    check("sb32_busy_after", int'(busy177), 0);
    check("sb32_idle_tx", int'(samp[177]), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
